rv32imf_alu_div_radix: RTL and testbench



---
 rtl/rv32imf_alu_div_radix.sv | 223 ++++++++++++++++++++++
 tb/tb_rv32imf_alu_div_radix.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rv32imf_alu_div_radix.sv
// rv32imf_alu_div_radix
// Iterative RV32M divider (DIV/DIVU/REM/REMU). Each DIVIDE cycle retires
// BITS_PER_CYCLE quotient bits through chained restoring compare/subtract
// stages that work on operand magnitudes. The sign is fixed up when the
// block enters FINISH.
//
// Optional feature macro: RV32IMF_DIV_EARLY_TERM_EN
//   defined   : leading-zero skip plus IDLE->FINISH bypass for divide-by-zero,
//               signed overflow and zero dividend (variable latency).
//   undefined : every operation runs WIDTH/BITS_PER_CYCLE DIVIDE cycles. The
//               special-case results are still chosen when entering FINISH.
//
// Ports:
//   Clk_CI, Rst_RBI       clock, asynchronous active-low reset
//   OpA_DI, OpB_DI        dividend, divisor
//   OpCode_SI             [1]=remainder/quotient select, [0]=signed
//   Tag_DI / Tag_DO       pass-through destination tag
//   InVld_SI / InRdy_SO   operand handshake
//   Kill_SI               flush, discards any operation in flight
//   OutVld_SO / OutRdy_SI result handshake
//   Res_DO                quotient or remainder
module rv32imf_alu_div_radix #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter int TAG_W          = 5
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic [WIDTH-1:0] OpA_DI,
  input  logic [WIDTH-1:0] OpB_DI,
  input  logic [1:0]       OpCode_SI,
  input  logic [TAG_W-1:0] Tag_DI,
  input  logic             InVld_SI,
  output logic             InRdy_SO,
  input  logic             Kill_SI,
  output logic             OutVld_SO,
  input  logic             OutRdy_SI,
  output logic [WIDTH-1:0] Res_DO,
  output logic [TAG_W-1:0] Tag_DO
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = ($clog2(ITERS) > 0) ? $clog2(ITERS) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rem_sel_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div0_q;
  logic             ovf_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] res_q;

  // Operand decode: magnitudes, sign flags and special-case detection.
  logic             sgn_in, a_neg, b_neg, b_zero, ovf_in, special;
  logic [WIDTH-1:0] a_abs, b_abs, dvd_load;
  logic [CNT_W-1:0] cnt_load;

  assign sgn_in = OpCode_SI[0];
  assign a_neg  = sgn_in & OpA_DI[WIDTH-1];
  assign b_neg  = sgn_in & OpB_DI[WIDTH-1];
  assign a_abs  = a_neg ? -OpA_DI : OpA_DI;
  assign b_abs  = b_neg ? -OpB_DI : OpB_DI;
  assign b_zero = (OpB_DI == '0);
  assign ovf_in = sgn_in & (OpA_DI == MIN_NEG) & (OpB_DI == '1);

`ifdef RV32IMF_DIV_EARLY_TERM_EN
  localparam int LZ_W = $clog2(WIDTH + 1);

  function automatic logic [LZ_W-1:0] lzc(input logic [WIDTH-1:0] v);
    logic [LZ_W-1:0] cnt;
    cnt = LZ_W'(WIDTH);
    // Scanning upward lets the highest set bit determine the count.
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) cnt = LZ_W'(WIDTH - 1 - i);
    end
    return cnt;
  endfunction

  logic [WIDTH-1:0] res_special;

  // Iteration count and preload. The skipped top bits of |A| are zero, so the
  // partial remainder starts at zero and the dividend is left-aligned to
  // the first iteration that can produce a non-zero quotient bit group.
  always_comb begin
    int sig_bits;
    int n_int;
    int skip;
    sig_bits = WIDTH - int'(lzc(a_abs));
    n_int    = (sig_bits + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    skip     = WIDTH - n_int * BITS_PER_CYCLE;
    cnt_load = CNT_W'(n_int - 1);
    dvd_load = a_abs << skip;
  end

  assign special = b_zero | ovf_in | (a_abs == '0);

  // Bypass results, taken straight from the raw operands.
  always_comb begin
    res_special = '0;
    if (b_zero)      res_special = OpCode_SI[1] ? OpA_DI : '1;
    else if (ovf_in) res_special = OpCode_SI[1] ? '0 : OpA_DI;
  end
`else
  assign special  = 1'b0;
  assign cnt_load = CNT_W'(ITERS - 1);
  assign dvd_load = a_abs;
`endif

  // One DIVIDE cycle: BITS_PER_CYCLE chained restoring stages.
  logic [WIDTH:0]   rem_t;
  logic [WIDTH-1:0] dvd_t, quo_t;

  always_comb begin
    rem_t = rem_q;
    dvd_t = dvd_q;
    quo_t = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_t = {rem_t[WIDTH-1:0], dvd_t[WIDTH-1]};
      dvd_t = {dvd_t[WIDTH-2:0], 1'b0};
      if (rem_t >= {1'b0, divisor_q}) begin
        rem_t = rem_t - {1'b0, divisor_q};
        quo_t = {quo_t[WIDTH-2:0], 1'b1};
      end else begin
        quo_t = {quo_t[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result of the final iteration with sign fix. With B=0 the restoring loop
  // already yields remainder |A|, so only the quotient needs overriding; the
  // overflow case is forced explicitly for clarity.
  logic [WIDTH-1:0] quo_fix, rem_fix, res_div;

  always_comb begin
    quo_fix = neg_quo_q ? -quo_t : quo_t;
    rem_fix = neg_rem_q ? -rem_t[WIDTH-1:0] : rem_t[WIDTH-1:0];
    if (div0_q) quo_fix = '1;
    if (ovf_q) begin
      quo_fix = MIN_NEG;
      rem_fix = '0;
    end
    res_div = rem_sel_q ? rem_fix : quo_fix;
  end

  logic accept, div_last;
  assign accept   = (state == IDLE) & InVld_SI & ~Kill_SI;
  assign div_last = (state == DIVIDE) & (cnt_q == '0) & ~Kill_SI;

  // State register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; kill wins from every state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (InVld_SI) state_nxt = special ? FINISH : DIVIDE;
      DIVIDE:  if (cnt_q == '0) state_nxt = FINISH;
      FINISH:  if (OutRdy_SI) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Kill_SI) state_nxt = IDLE;
  end

  // Datapath registers: operand capture, iteration, result capture.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      divisor_q <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      tag_q     <= '0;
      res_q     <= '0;
    end else begin
      if (accept) begin
        divisor_q <= b_abs;
        dvd_q     <= dvd_load;
        rem_q     <= '0;
        quo_q     <= '0;
        cnt_q     <= cnt_load;
        rem_sel_q <= OpCode_SI[1];
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        div0_q    <= b_zero;
        ovf_q     <= ovf_in;
        tag_q     <= Tag_DI;
`ifdef RV32IMF_DIV_EARLY_TERM_EN
        if (special) res_q <= res_special;
`endif
      end else if (state == DIVIDE) begin
        rem_q <= rem_t;
        dvd_q <= dvd_t;
        quo_q <= quo_t;
        cnt_q <= cnt_q - 1'b1;
        if (div_last) res_q <= res_div;
      end
    end
  end

  assign InRdy_SO  = (state == IDLE);
  assign OutVld_SO = (state == FINISH);
  assign Res_DO    = res_q;
  assign Tag_DO    = tag_q;

endmodule

// File: tb/tb_rv32imf_alu_div_radix.sv
// tb_rv32imf_alu_div_radix
// Table-driven bench for the radix divider at WIDTH=32, BITS_PER_CYCLE=2.
// Expected latency follows RV32IMF_DIV_EARLY_TERM_EN as compiled for the DUT.
module tb_rv32imf_alu_div_radix;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [1:0]  op_code = '0;
  logic [4:0]  tag_in = '0;
  logic        in_vld = 1'b0, kill = 1'b0, out_rdy = 1'b0;
  logic        in_rdy, out_vld;
  logic [31:0] res;
  logic [4:0]  tag_out;

  int tests = 0;
  int fails = 0;
  int lat;

  localparam logic [1:0] DIVU = 2'b00, DIV = 2'b01, REMU = 2'b10, REM = 2'b11;

  rv32imf_alu_div_radix #(.WIDTH(32), .BITS_PER_CYCLE(2), .TAG_W(5)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .OpA_DI(op_a), .OpB_DI(op_b), .OpCode_SI(op_code), .Tag_DI(tag_in),
    .InVld_SI(in_vld), .InRdy_SO(in_rdy), .Kill_SI(kill),
    .OutVld_SO(out_vld), .OutRdy_SI(out_rdy),
    .Res_DO(res), .Tag_DO(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[20];

  function automatic int latFor(input int early_lat);
`ifdef RV32IMF_DIV_EARLY_TERM_EN
    return early_lat;
`else
    return 17;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one operation and return after the accept edge (sampled #1 later).
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tg);
    int guard = 0;
    while (!in_rdy && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    op_code = op; op_a = a; op_b = b; tag_in = tg; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  // Count edges from the accept edge (inclusive) until OutVld is seen.
  task automatic waitResult(output int l);
    l = 1;
    while (!out_vld && l < 40) begin
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic handshake();
    @(negedge clk); out_rdy = 1'b1;
    @(posedge clk); #1; out_rdy = 1'b0;
  endtask

  initial begin
    int n_vec;
    int saw_vld;
    string nm;

    vecs[0]  = '{DIVU, 32'd100,        32'd7,          5'd3,  32'd14,         5};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          5'd4,  32'd2,          5};
    vecs[2]  = '{DIV,  32'hFFFFFFF9,   32'd2,          5'd5,  32'hFFFFFFFD,   3};
    vecs[3]  = '{REM,  32'hFFFFFFF9,   32'd2,          5'd6,  32'hFFFFFFFF,   3};
    vecs[4]  = '{DIV,  32'd7,          32'hFFFFFFFE,   5'd7,  32'hFFFFFFFD,   3};
    vecs[5]  = '{DIVU, 32'h1234,       32'd0,          5'd8,  32'hFFFFFFFF,   1};
    vecs[6]  = '{REM,  32'h1234,       32'd0,          5'd9,  32'h1234,       1};
    vecs[7]  = '{DIV,  32'h80000000,   32'hFFFFFFFF,   5'd10, 32'h80000000,   1};
    vecs[8]  = '{REM,  32'h80000000,   32'hFFFFFFFF,   5'd11, 32'd0,          1};
    vecs[9]  = '{DIVU, 32'hFFFFFFFF,   32'd3,          5'd12, 32'h55555555,   17};
    vecs[10] = '{REMU, 32'd0,          32'd5,          5'd13, 32'd0,          1};
    vecs[11] = '{DIVU, 32'd1,          32'd1,          5'd14, 32'd1,          2};
    vecs[12] = '{DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   5'd15, 32'd3,          3};
    vecs[13] = '{REM,  32'hFFFFFFF9,   32'hFFFFFFFE,   5'd16, 32'hFFFFFFFF,   3};
    vecs[14] = '{DIVU, 32'h80000000,   32'hFFFFFFFF,   5'd17, 32'd0,          17};
    vecs[15] = '{REMU, 32'h80000000,   32'hFFFFFFFF,   5'd18, 32'h80000000,   17};
    vecs[16] = '{DIV,  32'hFFFFFFFF,   32'd0,          5'd19, 32'hFFFFFFFF,   1};
    vecs[17] = '{REM,  32'hFFFFFFFF,   32'd0,          5'd20, 32'hFFFFFFFF,   1};
    vecs[18] = '{DIVU, 32'd1000,       32'd10,         5'd21, 32'd100,        6};
    vecs[19] = '{REMU, 32'h12345678,   32'h100,        5'd22, 32'h78,         16};
    n_vec = 20;

    // Reset state.
    #12;
    checkOutput("reset_inrdy",  {31'd0, in_rdy},  32'd1);
    checkOutput("reset_outvld", {31'd0, out_vld}, 32'd0);
    checkOutput("reset_res",    res,              32'd0);
    checkOutput("reset_tag",    {27'd0, tag_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < n_vec; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      waitResult(lat);
      $sformat(nm, "vec%0d_res", i);   checkOutput(nm, res, vecs[i].exp_res);
      $sformat(nm, "vec%0d_tag", i);   checkOutput(nm, {27'd0, tag_out}, {27'd0, vecs[i].tag});
      $sformat(nm, "vec%0d_lat", i);   checkOutput(nm, lat, latFor(vecs[i].exp_lat));
      handshake();
      $sformat(nm, "vec%0d_inrdy", i); checkOutput(nm, {31'd0, in_rdy}, 32'd1);
    end

    // Backpressure: result held stable while the consumer stalls.
    applyStimulus(DIVU, 32'd100, 32'd7, 5'd9);
    waitResult(lat);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("bp_res",    res,               32'd14);
      checkOutput("bp_tag",    {27'd0, tag_out},  32'd9);
      checkOutput("bp_outvld", {31'd0, out_vld},  32'd1);
      checkOutput("bp_inrdy",  {31'd0, in_rdy},   32'd0);
    end
    handshake();
    checkOutput("bp_inrdy_after", {31'd0, in_rdy}, 32'd1);

    // Kill on the second DIVIDE cycle.
    applyStimulus(DIVU, 32'hFFFFFFFF, 32'd3, 5'd1);
    @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    checkOutput("kill_inrdy",  {31'd0, in_rdy},  32'd1);
    checkOutput("kill_outvld", {31'd0, out_vld}, 32'd0);
    saw_vld = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_vld) saw_vld = 1;
    end
    checkOutput("kill_no_vld", saw_vld, 0);

    // Kill together with InVld in IDLE is not an accept.
    @(negedge clk);
    op_code = DIVU; op_a = 32'd50; op_b = 32'd5; tag_in = 5'd2; in_vld = 1'b1; kill = 1'b1;
    @(posedge clk); #1; in_vld = 1'b0; kill = 1'b0;
    checkOutput("killacc_inrdy", {31'd0, in_rdy}, 32'd1);
    saw_vld = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_vld) saw_vld = 1;
    end
    checkOutput("killacc_no_vld", saw_vld, 0);

    // New operation after the kill.
    applyStimulus(DIVU, 32'd9, 32'd3, 5'd4);
    waitResult(lat);
    checkOutput("post_kill_res", res, 32'd3);
    checkOutput("post_kill_lat", lat, latFor(3));
    handshake();

    // Asynchronous reset mid-DIVIDE; Res_DO still holds 3 from before.
    applyStimulus(DIVU, 32'hFFFFFFFF, 32'd3, 5'd7);
    @(posedge clk);
    @(negedge clk); #2; rst_n = 1'b0;
    #1;
    checkOutput("arst_outvld", {31'd0, out_vld}, 32'd0);
    checkOutput("arst_res",    res,              32'd0);
    checkOutput("arst_tag",    {27'd0, tag_out}, 32'd0);
    checkOutput("arst_inrdy",  {31'd0, in_rdy},  32'd1);
    @(negedge clk); rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
